uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmit byte channel (the stream feeding the `txd` serializer on `sys_clk`) between `NUM_REQ` byte-stream requesters, such as the core's MMIO console and the cosim trace dumper. Grants are round-robin and held for a whole burst, so lines from different sources never interleave mid-message. A burst ends on `last`, on a burst-length cap, or on a stall timeout. The block sits between the requesters and the UART TX FIFO.

## Interface
- `NUM_REQ`, 2: number of requesters; 2..8.
- `MAX_BURST`, 64: maximum bytes per grant; 1..256.
- `STALL_TIMEOUT`, 16: consecutive cycles the granted requester may hold `req_valid` low before its grant is revoked; ≥1.
- `sys_clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  byte valid, one bit per requester.
- `req_data`  in  NUM_REQ*8  bytes; requester i drives `[8i+7:8i]`.
- `req_last`  in  NUM_REQ  marks the final byte of a burst.
- `req_ready`  out  NUM_REQ  byte accepted when valid & ready.
- `tx_valid`  out  1  byte valid towards the UART TX.
- `tx_data`  out  8  byte towards the UART TX.
- `tx_ready`  in  1  UART TX can accept a byte.
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `busy`  out  1  a grant is held.

## Operation
- States: IDLE, TAG (only with the macro), GRANT.
- IDLE: if any `req_valid`, choose the first requester with valid set, searching upward (with wrap) from `last_grant+1`.
  - Register the winner into `grant`.
  - Go to TAG if the macro is defined, else go to GRANT.
- GRANT, pass-through from the owner g:
  - `tx_valid=req_valid[g]`, `tx_data=req_data[g]`.
  - `req_ready[g]=tx_ready`; every other `req_ready` bit is 0.
- Transfer means `tx_valid & tx_ready`. Each transfer increments `byte_cnt` (8-bit plus one extra bit, so the value MAX_BURST fits).
- The burst ends on a transfer with `req_last[g]`, or on a transfer when `byte_cnt==MAX_BURST-1`. On burst end:
  - IDLE next cycle, `last_grant<=g`, `byte_cnt<=0`.
- Stall counter:
  - Counts cycles in GRANT with `req_valid[g]==0`.
  - Clears on any cycle where `req_valid[g]` is high.
  - Reaching `STALL_TIMEOUT` sends the FSM to IDLE with `last_grant<=g`; no byte is lost.
- A cycle where `tx_ready` is low while `req_valid[g]` is high is backpressure, not a stall.
- Non-owners are never granted `req_ready` and must hold their data stable.

## Timing
- Reset values:
  - All outputs 0, state IDLE, `byte_cnt=0`, stall counter 0.
  - `last_grant=NUM_REQ-1`, so requester 0 wins first.
- Grant latency:
  - Without the macro, `req_valid` rising in IDLE leads to `grant` and a pass-through byte the next cycle (1 cycle).
  - With the macro, the extra TAG cycle(s) come first.
- Dead cycle: exactly one IDLE cycle between consecutive bursts, even when the same requester wants the next burst.
- Simultaneous requests in IDLE: the rotating priority decides. With `last_grant=0` and requests 0 and 1 both asserted, requester 1 wins.
- `req_last` and the MAX_BURST limit on the same transfer: the burst ends once; no double count.
- Reset during GRANT: `rst` has priority; all outputs drop to 0 in the next cycle and any partly sent burst is abandoned.
- `tx_valid`/`tx_data` are combinational from the owner during GRANT. `grant`, `busy` and the state are registered.

## Configuration
- `UART_ARB_TAG_EN` defined:
  - After arbitration, the FSM enters TAG.
  - It drives `tx_valid=1`, `tx_data=8'h30+g` (ASCII digit), with all `req_ready=0`.
  - It holds TAG until `tx_ready`, then goes to GRANT.
  - The tag byte does not count toward MAX_BURST.
- Undefined: no TAG state, no tag logic.

## Structure
- Package `UartArbPack`: state enum `ArbState` (IDLE, TAG, GRANT) and constant `TAG_BASE=8'h30`.
- Sub-module `uart_rr_picker`: combinational rotating-priority picker.
  - Inputs: `req`, `last_grant`.
  - Outputs: one-hot `pick`, index, `any`.
- The FSM, counters and muxing live in the top.

## Test plan
- Single requester 0 sends bytes 0x41, 0x42, 0x0A (last on 0x0A), `tx_ready=1` -> `tx_data` shows 41, 42, 0A on consecutive cycles; `grant` is 01 for 3 cycles; then IDLE.
- Both requesters assert at once after reset -> requester 0 granted first; requester 1 granted after 0's last byte plus one dead cycle.
- `MAX_BURST=4`, requester 1 streams 6 bytes without last -> grant released after 4 bytes; remaining 2 are sent in the next grant when no other requester is asking.
- Owner drops valid for `STALL_TIMEOUT=16` cycles -> `busy` falls on the 17th cycle; a waiting requester 0 is granted the next cycle.
- `tx_ready` held low for 10 cycles mid-burst -> no timeout, no byte loss, `req_ready` is 0 throughout.
- With `UART_ARB_TAG_EN`, requester 1 sends 0x5A(last) -> `tx_data` sequence is 0x31, 0x5A. Separately, `rst` pulsed mid-burst -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types and constants for the UART TX arbiter
package UartArbPack;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAG   = 2'd1,
    GRANT = 2'd2
  } ArbState;

  // ASCII '0'; the source tag byte is TAG_BASE + requester index
  localparam logic [7:0] TAG_BASE = 8'h30;

endpackage

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational rotating-priority picker, search starts after last_grant
module uart_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] pick,
  output logic [IW-1:0]      pick_idx,
  output logic               any
);

  int          cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any            = 1'b1;
        pick[cand_idx] = 1'b1;
        pick_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - burst-holding round-robin arbiter for the UART TX byte channel
// Define UART_ARB_TAG_EN to prefix each burst with an ASCII source-tag byte.
module uart_tx_arbiter
  import UartArbPack::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int MAX_BURST     = 64,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int              IW        = $clog2(NUM_REQ);
  localparam int              SW        = $clog2(STALL_TIMEOUT + 1);
  localparam logic [8:0]      BURST_END = 9'(MAX_BURST - 1);
  localparam logic [SW-1:0]   STALL_LIM = SW'(STALL_TIMEOUT);

  ArbState              state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        last_grant_q, last_grant_d;
  logic [8:0]           byte_cnt_q, byte_cnt_d;
  logic [SW-1:0]        stall_q, stall_d;

  logic [NUM_REQ-1:0]   pick;
  logic [IW-1:0]        pick_idx;
  logic                 any_req;

  logic                 own_valid;
  logic                 own_last;
  logic [7:0]           own_data;
  logic                 xfer;
  logic [SW-1:0]        stall_inc;
  logic                 burst_done;
  logic                 stall_done;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .any        (any_req)
  );

  assign own_valid  = req_valid[owner_q];
  assign own_last   = req_last[owner_q];
  assign own_data   = req_data[{owner_q, 3'b000} +: 8];
  assign xfer       = (state_q == GRANT) && own_valid && tx_ready;
  assign stall_inc  = stall_q + 1'b1;
  // last and the length cap can coincide on one transfer; either closes the burst once
  assign burst_done = xfer && (own_last || (byte_cnt_q == BURST_END));
  assign stall_done = (state_q == GRANT) && !own_valid && (stall_inc == STALL_LIM);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      byte_cnt_q   <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      stall_q      <= stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    stall_d      = stall_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d    = pick;
          owner_d    = pick_idx;
          byte_cnt_d = '0;
          stall_d    = '0;
`ifdef UART_ARB_TAG_EN
          state_d    = TAG;
`else
          state_d    = GRANT;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        if (tx_ready) begin
          state_d = GRANT;
        end
      end
`endif
      GRANT: begin
        stall_d = own_valid ? '0 : stall_inc;
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 9'd1;
        end
        if (burst_done || stall_done) begin
          state_d      = IDLE;
          grant_d      = '0;
          last_grant_d = owner_q;
          byte_cnt_d   = '0;
          stall_d      = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    case (state_q)
`ifdef UART_ARB_TAG_EN
      TAG: begin
        tx_valid = 1'b1;
        tx_data  = TAG_BASE + 8'(owner_q);
      end
`endif
      GRANT: begin
        tx_valid  = own_valid;
        tx_data   = own_data;
        req_ready = grant_q & {NUM_REQ{tx_ready}};
      end
      default: begin
        tx_valid  = 1'b0;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized bench for uart_tx_arbiter against a reference model
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int MB = 4;
  localparam int TO = 16;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(
    .NUM_REQ       (NR),
    .MAX_BURST     (MB),
    .STALL_TIMEOUT (TO)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
  );

  // requester byte queues: {last, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] dut_log[$];
  bit         on0, on1, rdy;
  int         nvec = 0;
  int         nerr = 0;
  int         g0_cycles = 0;

  // reference model: 0 idle, 1 tag, 2 granted
  int m_state = 0;
  int m_owner = 0;
  int m_last  = NR - 1;
  int m_cnt   = 0;
  int m_stall = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    tx_ready     = rdy;
    req_valid[0] = on0 && (q0.size() != 0);
    req_last[0]  = (q0.size() != 0) ? q0[0][8] : 1'b0;
    req_data[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    req_valid[1] = on1 && (q1.size() != 0);
    req_last[1]  = (q1.size() != 0) ? q1[0][8] : 1'b0;
    req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
  endtask

  task automatic model_check();
    logic [1:0] eg, er;
    logic       ev, eb, ov, ol, xf, oi, found;
    logic [7:0] ed, odata;
    int         c;
    oi    = m_owner[0];
    ov    = req_valid[oi];
    ol    = req_last[oi];
    odata = oi ? req_data[15:8] : req_data[7:0];
    eg    = (m_state == 0) ? 2'b00 : (oi ? 2'b10 : 2'b01);
    eb    = (m_state != 0);
    ev    = 1'b0;
    ed    = 8'h00;
    er    = 2'b00;
    if (m_state == 1) begin
      ev = 1'b1;
      ed = 8'h30 + {7'd0, oi};
    end
    if (m_state == 2) begin
      ev = ov;
      ed = odata;
      er = tx_ready ? eg : 2'b00;
    end
    chk("tx_valid", 16'(tx_valid), 16'(ev));
    chk("tx_data", 16'(tx_data), 16'(ed));
    chk("req_ready", 16'(req_ready), 16'(er));
    chk("grant", 16'(grant), 16'(eg));
    chk("busy", 16'(busy), 16'(eb));
    if (tx_valid && tx_ready && (req_ready != 2'b00)) dut_log.push_back(tx_data);
    if (grant == 2'b01) g0_cycles++;
    xf = (m_state == 2) && ov && tx_ready;
    if (xf) begin
      if (oi) q1.delete(0);
      else q0.delete(0);
    end
    if (rst) begin
      m_state = 0; m_last = NR - 1; m_cnt = 0; m_stall = 0;
    end else begin
      case (m_state)
        0: begin
          found = 1'b0;
          for (int k = 1; k <= NR; k++) begin
            c = (m_last + k) % NR;
            if (!found && req_valid[c[0]]) begin
              found   = 1'b1;
              m_owner = c;
            end
          end
          if (found) begin
            m_state = TAG_EN ? 1 : 2;
            m_cnt   = 0;
            m_stall = 0;
          end
        end
        1: if (tx_ready) m_state = 2;
        default: begin
          if (xf) begin
            m_cnt++;
            if (ol || m_cnt == MB) begin
              m_state = 0; m_last = m_owner;
            end
          end else if (!ov) begin
            m_stall++;
            if (m_stall == TO) begin
              m_state = 0; m_last = m_owner;
            end
          end
          if (ov) m_stall = 0;
        end
      endcase
    end
  endtask

  task automatic step();
    drive();
    @(negedge sys_clk);
    model_check();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_grant(input logic [1:0] g);
    int n = 0;
    while (grant !== g && n < 20) begin
      step();
      n++;
    end
    chk("wait_grant", 16'(grant), 16'(g));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tx_valid"}, 16'(tx_valid), 16'd0);
    chk({tag, "_grant"}, 16'(grant), 16'd0);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_req_ready"}, 16'(req_ready), 16'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; on0 = 1'b0; on1 = 1'b0; rdy = 1'b1;
    drive();
    @(posedge sys_clk);
    #1;
    repeat (2) step();
    check_idle_outputs("reset");
    rst = 1'b0;

    // single requester 0: 41 42 0A(last)
    g0_cycles = 0;
    dut_log.delete();
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b0, 8'h42});
    q0.push_back({1'b1, 8'h0A});
    on0 = 1'b1;
    repeat (8) step();
    chk("t1_count", 16'(dut_log.size()), 16'd3);
    if (dut_log.size() == 3) begin
      chk("t1_b0", 16'(dut_log[0]), 16'h41);
      chk("t1_b1", 16'(dut_log[1]), 16'h42);
      chk("t1_b2", 16'(dut_log[2]), 16'h0A);
    end
    chk("t1_grant_cycles", 16'(g0_cycles), TAG_EN ? 16'd4 : 16'd3);

    // both requesters right after reset: 0 first, then 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    dut_log.delete();
    q0.push_back({1'b0, 8'h11});
    q0.push_back({1'b1, 8'h12});
    q1.push_back({1'b0, 8'h21});
    q1.push_back({1'b1, 8'h22});
    on0 = 1'b1; on1 = 1'b1;
    repeat (12) step();
    chk("t2_count", 16'(dut_log.size()), 16'd4);
    if (dut_log.size() == 4) begin
      chk("t2_b0", 16'(dut_log[0]), 16'h11);
      chk("t2_b1", 16'(dut_log[1]), 16'h12);
      chk("t2_b2", 16'(dut_log[2]), 16'h21);
      chk("t2_b3", 16'(dut_log[3]), 16'h22);
    end

    // burst cap: six bytes with no last from requester 1
    dut_log.delete();
    on0 = 1'b0; on1 = 1'b1;
    for (int i = 0; i < 6; i++) q1.push_back({1'b0, 8'(8'h60 + i)});
    repeat (34) step();
    chk("t3_count", 16'(dut_log.size()), 16'd6);
    if (dut_log.size() == 6) begin
      chk("t3_b3", 16'(dut_log[3]), 16'h63);
      chk("t3_b5", 16'(dut_log[5]), 16'h65);
    end

    // stall timeout while requester 0 waits
    q1.push_back({1'b0, 8'h70});
    q1.push_back({1'b0, 8'h71});
    q1.push_back({1'b0, 8'h72});
    on1 = 1'b1;
    wait_grant(2'b10);
    if (TAG_EN) step();
    step();
    on1 = 1'b0;
    q0.push_back({1'b1, 8'h55});
    on0 = 1'b1;
    n = 0;
    while (grant === 2'b10 && n < 40) begin
      step();
      n++;
    end
    chk("stall_len", 16'(n), 16'(TO));
    n = 0;
    while (grant !== 2'b01 && n < 10) begin
      step();
      n++;
    end
    chk("after_stall_grant", 16'(n), 16'd1);
    on1 = 1'b1;
    repeat (40) step();

    // backpressure mid-burst
    dut_log.delete();
    on1 = 1'b0; on0 = 1'b1;
    q0.push_back({1'b0, 8'h81});
    q0.push_back({1'b0, 8'h82});
    q0.push_back({1'b0, 8'h83});
    q0.push_back({1'b1, 8'h84});
    wait_grant(2'b01);
    if (TAG_EN) step();
    repeat (2) step();
    rdy = 1'b0;
    repeat (10) begin
      step();
      chk("bp_req_ready", 16'(req_ready), 16'd0);
      chk("bp_grant", 16'(grant), 16'h1);
    end
    rdy = 1'b1;
    repeat (6) step();
    chk("bp_count", 16'(dut_log.size()), 16'd4);
    if (dut_log.size() == 4) chk("bp_b3", 16'(dut_log[3]), 16'h84);

    // reset mid-burst
    on0 = 1'b0; on1 = 1'b1;
    for (int i = 0; i < 6; i++) q1.push_back({1'b0, 8'(8'h90 + i)});
    wait_grant(2'b10);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("rst_mid");
    repeat (30) step();

    // randomized traffic with stall-heavy phases and rare resets
    for (int i = 0; i < 700; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 3) == 0)
        q0.push_back({($urandom_range(0, 3) == 0), 8'($urandom)});
      if (q1.size() < 3 && $urandom_range(0, 3) == 0)
        q1.push_back({($urandom_range(0, 3) == 0), 8'($urandom)});
      if ((i / 50) % 3 == 2) begin
        on0 = ($urandom_range(0, 9) == 0);
        on1 = ($urandom_range(0, 9) == 0);
      end else begin
        on0 = ($urandom_range(0, 9) < 8);
        on1 = ($urandom_range(0, 9) < 8);
      end
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
